// File: rtl/bp_update_queue.sv
// Branch-update queue in front of the checkpointed BTB pair; each entry remembers its bank.
// Optional PC/tag coalescing of resident entries is enabled by defining BP_UPDQ_COALESCE_EN.
package ariane_pkg;
    localparam int unsigned VLEN = 64;
    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target_address;
    } btb_update_t;
endpackage

module bp_update_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      stall_i,
    input  logic                      checkpoint_mode_i,
    input  ariane_pkg::btb_update_t   resolved_update_i,
    output ariane_pkg::btb_update_t   btb_update_o,
    output logic                      checkpoint_mode_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                      overflow_o,
    output logic [15:0]               drop_cnt_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    typedef logic [ariane_pkg::VLEN-1:0] addr_t;

    addr_t             pc_q  [DEPTH];
    addr_t             tgt_q [DEPTH];
    logic [DEPTH-1:0]  tag_q;
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic [15:0]       drop_q;

    logic empty, full, pop, in_vld, coalesce, push, drop;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CW'(DEPTH));
    assign pop    = !empty && !stall_i && !flush_i;
    assign in_vld = resolved_update_i.valid && !flush_i;

`ifdef BP_UPDQ_COALESCE_EN
    logic          hit_any;
    logic [PW-1:0] hit_idx, scan_idx;

    // Scan oldest to youngest so the youngest matching entry wins; the head is
    // skipped when it leaves this cycle.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        scan_idx = '0;
        for (int a = 0; a < DEPTH; a++) begin
            scan_idx = rd_ptr_q + PW'(a);
            if (CW'(a) < cnt_q && !(a == 0 && pop) &&
                pc_q[scan_idx] == resolved_update_i.pc &&
                tag_q[scan_idx] == checkpoint_mode_i) begin
                hit_any = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end
    assign coalesce = in_vld && hit_any;
`else
    assign coalesce = 1'b0;
`endif

    assign push = in_vld && !coalesce && (!full || pop);
    assign drop = in_vld && !coalesce && full && !pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
        end else begin
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_q[wr_ptr_q]  <= resolved_update_i.pc;
            tgt_q[wr_ptr_q] <= resolved_update_i.target_address;
            tag_q[wr_ptr_q] <= checkpoint_mode_i;
        end
`ifdef BP_UPDQ_COALESCE_EN
        else if (coalesce) begin
            tgt_q[hit_idx] <= resolved_update_i.target_address;
        end
`endif
    end

    always_comb begin
        btb_update_o = '0;
        if (pop) begin
            btb_update_o.valid          = 1'b1;
            btb_update_o.pc             = pc_q[rd_ptr_q];
            btb_update_o.target_address = tgt_q[rd_ptr_q];
        end
    end

    assign checkpoint_mode_o = empty ? checkpoint_mode_i : tag_q[rd_ptr_q];
    assign full_o            = full;
    assign empty_o           = empty;
    assign count_o           = cnt_q;
    assign overflow_o        = drop;
    assign drop_cnt_o        = drop_q;

endmodule

// File: tb/tb_bp_update_queue.sv
// Scoreboard bench for bp_update_queue: stimulus queues expected pops, a negedge monitor checks them.
module tb_bp_update_queue;
    logic clk = 1'b0;
    logic rst_n, flush, stall, mode_i;
    ariane_pkg::btb_update_t upd_in, upd_out;
    logic       mode_o, full, empty, ovf;
    logic [2:0] cnt;
    logic [15:0] drop_cnt;

    bp_update_queue #(.DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .stall_i(stall),
        .checkpoint_mode_i(mode_i), .resolved_update_i(upd_in),
        .btb_update_o(upd_out), .checkpoint_mode_o(mode_o),
        .full_o(full), .empty_o(empty), .count_o(cnt),
        .overflow_o(ovf), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; logic [63:0] tgt; logic mode; } exp_t;
    exp_t exp_q[$];
    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic v, input logic [63:0] pc, input logic [63:0] tgt,
                       input logic m, input logic st, input logic fl);
        upd_in.valid = v; upd_in.pc = pc; upd_in.target_address = tgt;
        mode_i = m; stall = st; flush = fl;
    endtask

    task automatic expect_pop(input logic [63:0] pc, input logic [63:0] tgt, input logic m);
        exp_t e;
        e.pc = pc; e.tgt = tgt; e.mode = m;
        exp_q.push_back(e);
    endtask

    task automatic go();
        @(posedge clk); #1;
    endtask

    // Monitor: every valid output must match the oldest expected update.
    always @(negedge clk) begin
        if (rst_n && upd_out.valid) begin
            if (exp_q.size() == 0) begin
                vecs++; errs++;
                $display("FAIL unexpected_pop: got pc %0h want no pop at %0t", upd_out.pc, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pop_pc",   upd_out.pc, e.pc);
                chk("pop_tgt",  upd_out.target_address, e.tgt);
                chk("pop_mode", 64'(mode_o), 64'(e.mode));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 1, 0, 0);
        #3;
        chk("rst_valid", 64'(upd_out.valid), 0);
        chk("rst_pc",    upd_out.pc, 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_full",  64'(full), 0);
        chk("rst_count", 64'(cnt), 0);
        chk("rst_ovf",   64'(ovf), 0);
        chk("rst_drop",  64'(drop_cnt), 0);
        chk("rst_mode",  64'(mode_o), 1);
        go(); go();
        rst_n = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        go();

        // Basic order, continuous drain
        drv(1, 64'h100, 64'h1100, 0, 0, 0); expect_pop(64'h100, 64'h1100, 0);
        @(negedge clk); chk("basic_cnt0", 64'(cnt), 0); chk("basic_empty0", 64'(empty), 1);
        go();
        drv(1, 64'h200, 64'h1200, 0, 0, 0); expect_pop(64'h200, 64'h1200, 0);
        @(negedge clk); chk("basic_cnt1", 64'(cnt), 1);
        go();
        drv(1, 64'h300, 64'h1300, 0, 0, 0); expect_pop(64'h300, 64'h1300, 0);
        @(negedge clk); chk("basic_cnt2", 64'(cnt), 1);
        go();
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("basic_cnt3", 64'(cnt), 1);
        go();
        @(negedge clk); chk("basic_empty", 64'(empty), 1); chk("basic_cnt_end", 64'(cnt), 0);

        // Mode tagging while stalled; empty queue forwards mode_i
        drv(0, 0, 0, 1, 1, 0);
        @(negedge clk); chk("empty_mode_track", 64'(mode_o), 1);
        go();
        drv(1, 64'h100, 64'h2100, 0, 1, 0); expect_pop(64'h100, 64'h2100, 0); go();
        drv(1, 64'h200, 64'h2200, 1, 1, 0); expect_pop(64'h200, 64'h2200, 1); go();
        drv(1, 64'h300, 64'h2300, 0, 1, 0); expect_pop(64'h300, 64'h2300, 0); go();
        drv(0, 0, 0, 1, 1, 0);
        @(negedge clk);
        chk("tag_cnt3", 64'(cnt), 3);
        chk("tag_head_mode", 64'(mode_o), 0);
        chk("tag_valid_stalled", 64'(upd_out.valid), 0);
        go();
        drv(0, 0, 0, 1, 0, 0);
        repeat (4) go();
        @(negedge clk); chk("tag_empty", 64'(empty), 1);

        // Overflow: fill while stalled, fifth is dropped
        for (int k = 0; k < 4; k++) begin
            drv(1, 64'h400 + 64'(k) * 64'h100, 64'h1400 + 64'(k), 0, 1, 0);
            expect_pop(64'h400 + 64'(k) * 64'h100, 64'h1400 + 64'(k), 0);
            go();
        end
        drv(1, 64'h800, 64'h1800, 0, 1, 0);
        @(negedge clk);
        chk("ovf_pulse", 64'(ovf), 1);
        chk("ovf_full", 64'(full), 1);
        chk("ovf_cnt", 64'(cnt), 4);
        go();
        drv(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("ovf_pulse_end", 64'(ovf), 0);
        chk("ovf_drop_cnt", 64'(drop_cnt), 1);
        chk("ovf_still_full", 64'(full), 1);
        go();
        drv(1, 64'h900, 64'h1900, 1, 0, 0); expect_pop(64'h900, 64'h1900, 1);
        @(negedge clk); chk("full_pop_no_ovf", 64'(ovf), 0);
        go();
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("full_pop_drop_cnt", 64'(drop_cnt), 1);
        chk("full_pop_cnt", 64'(cnt), 4);
        repeat (5) go();
        @(negedge clk); chk("ovf_drained", 64'(empty), 1);

        // Flush with a simultaneous push
        drv(1, 64'hA10, 64'h1, 0, 1, 0); go();
        drv(1, 64'hA20, 64'h2, 0, 1, 0); go();
        drv(1, 64'hA30, 64'h3, 0, 1, 0); go();
        drv(1, 64'hF00, 64'hF00, 0, 0, 1);
        @(negedge clk);
        chk("flush_no_pop", 64'(upd_out.valid), 0);
        chk("flush_no_ovf", 64'(ovf), 0);
        chk("flush_cnt_before", 64'(cnt), 3);
        go();
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("flush_empty", 64'(empty), 1);
        chk("flush_cnt", 64'(cnt), 0);
        chk("flush_drop_kept", 64'(drop_cnt), 1);
        chk("flush_valid", 64'(upd_out.valid), 0);
        go(); go();

        // Coalescing: same pc/mode merges only with the feature on
        drv(1, 64'h100, 64'hA00, 0, 1, 0); go();
        drv(1, 64'h100, 64'hB00, 0, 1, 0); go();
        drv(1, 64'h100, 64'hC00, 1, 1, 0); go();
        drv(0, 0, 0, 0, 1, 0);
`ifdef BP_UPDQ_COALESCE_EN
        @(negedge clk); chk("coal_cnt", 64'(cnt), 2);
        expect_pop(64'h100, 64'hB00, 0);
`else
        @(negedge clk); chk("coal_cnt", 64'(cnt), 3);
        expect_pop(64'h100, 64'hA00, 0);
        expect_pop(64'h100, 64'hB00, 0);
`endif
        expect_pop(64'h100, 64'hC00, 1);
        go();
        drv(0, 0, 0, 0, 0, 0);
        repeat (4) go();
        @(negedge clk); chk("coal_drained", 64'(empty), 1);

        // Asynchronous reset with a valid output present
        drv(1, 64'h111, 64'h1111, 0, 1, 0); expect_pop(64'h111, 64'h1111, 0); go();
        drv(1, 64'h222, 64'h2222, 0, 1, 0); expect_pop(64'h222, 64'h2222, 0); go();
        drv(0, 0, 0, 1, 0, 0);
        go();
        #1;
        chk("areset_pre_valid", 64'(upd_out.valid), 1);
        rst_n = 1'b0;
        #1;
        chk("areset_valid", 64'(upd_out.valid), 0);
        chk("areset_pc", upd_out.pc, 0);
        chk("areset_empty", 64'(empty), 1);
        chk("areset_cnt", 64'(cnt), 0);
        chk("areset_drop", 64'(drop_cnt), 0);
        chk("areset_mode", 64'(mode_o), 1);
        exp_q.delete();
        go(); go();
        rst_n = 1'b1;
        go(); go();

        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/bp_update_queue.md
# bp_update_queue

Buffers resolved branch updates from the branch unit and drains them, one per cycle, into the checkpointed BTB pair (`btb_mux`). Each entry is tagged with the `checkpoint_mode_i` value at enqueue time. The queue drives the bank-select seen by the BTB pair, so every update lands in the bank that was active when the branch resolved, even if the checkpoint mode flips while updates are pending. It sits between the execute-stage branch unit and the frontend BTB.

## Interface
Parameters:
- `DEPTH`, default 4: number of queue entries; power of two, ≥2.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous reset, active low.
- `flush_i`  in  1  clear all entries.
- `stall_i`  in  1  hold draining (frontend busy).
- `checkpoint_mode_i`  in  1  current bank select from the checkpoint controller.
- `resolved_update_i`  in  `ariane_pkg::btb_update_t`  update from the branch unit; `.valid` qualifies it.
- `btb_update_o`  out  `ariane_pkg::btb_update_t`  update to `btb_mux`.
- `checkpoint_mode_o`  out  1  bank select to `btb_mux`.
- `full_o`  out  1  count == DEPTH.
- `empty_o`  out  1  count == 0.
- `count_o`  out  `$clog2(DEPTH+1)`  occupied entries.
- `overflow_o`  out  1  one-cycle pulse when an update is dropped.
- `drop_cnt_o`  out  16  saturating count of dropped updates.

## Operation
- Storage is a circular buffer of `{pc, target_address, tag}` with read and write pointers of `$clog2(DEPTH)` bits. Pointers wrap naturally. A separate count register disambiguates full from empty.
- **Enqueue:** occurs when `resolved_update_i.valid` is high and the update is neither coalesced nor dropped. The new entry gets `tag = checkpoint_mode_i`.
- **Pop:**
  - `pop = !empty && !stall_i && !flush_i`.
  - `btb_update_o = {valid: pop, pc/target: head entry}`.
  - When `!pop`, `btb_update_o` is all zeros.
- **Bank select:** `checkpoint_mode_o` is the head tag when not empty; otherwise it is `checkpoint_mode_i`. It is combinational, so it is aligned with `btb_update_o` in the same cycle.
- **Simultaneous push and pop:** both take effect; count is unchanged.
- **Full:**
  - Full with a simultaneous pop: the incoming update is accepted.
  - Full without a pop, and not coalesced: the update is dropped. `overflow_o` pulses and `drop_cnt_o` increments, saturating at 16'hFFFF.
- **Flush:**
  - Pointers and count are cleared next edge.
  - An enqueue in the same cycle is discarded and is not counted as a drop.
  - No pop occurs.
  - `drop_cnt_o` is not cleared by flush.
- **Coalescing** (see Configuration):
  - Applies when an incoming valid update matches the `pc` and tag of a resident entry.
  - The matching entry's `target_address` is overwritten and no new entry is allocated.
  - The entry being popped this cycle is excluded from matching; in that case a normal allocation occurs.
  - If multiple entries match, the youngest is updated.

## Timing
- Enqueue latency: an update accepted at edge N appears on `btb_update_o` in the cycle after edge N, at the earliest. There is no same-cycle bypass.
- Throughput: one enqueue and one pop per cycle.
- `full_o`, `empty_o` and `count_o` are registered-state derived and reflect the state after the previous edge.
- `overflow_o` is combinational in the cycle of the dropped update.
- Reset values:
  - `btb_update_o` = '0.
  - `empty_o` = 1; `full_o` = 0; `count_o` = 0.
  - `overflow_o` = 0; `drop_cnt_o` = 0.
  - `checkpoint_mode_o` = `checkpoint_mode_i`.
- Reset asserted mid-operation discards all entries immediately (asynchronous).

## Configuration
- `BP_UPDQ_COALESCE_EN` defined: PC/tag match coalescing is enabled as described in Operation. The match requires one comparator per entry.
- Not defined: every valid update allocates a new entry; duplicates are drained in order. The comparators are removed.

## Test plan
- **Basic order:** with DEPTH=4, reset, then push pc 0x100/0x200/0x300 on consecutive cycles with mode 0 → three pops in order starting the cycle after the first push, each with `checkpoint_mode_o`=0. `count_o` peaks at 1 if draining continuously, or at 3 with `stall_i` held.
- **Mode tagging:** with `stall_i`=1, push 0x100 (mode 0), then 0x200 (mode 1), then release the stall → the pop of 0x100 sees `checkpoint_mode_o`=0 and the pop of 0x200 sees 1. While empty, `checkpoint_mode_o` tracks `checkpoint_mode_i`.
- **Overflow:** with `stall_i`=1, push 5 updates → the 5th is dropped, `overflow_o` pulses once, `drop_cnt_o`=1, and `full_o`=1. Then push with `stall_i`=0 while full → accepted, no drop.
- **Flush:** with 3 entries queued, assert `flush_i` together with a valid push → next cycle `empty_o`=1, `count_o`=0, no output valid, and `drop_cnt_o` unchanged.
- **Coalesce (macro on):** with the queue stalled holding 0x100→0xA00, push 0x100→0xB00 (same mode) → `count_o` stays 1 and the pop emits target 0xB00. Same push with a different mode → a new entry is allocated. With the macro off → count 2, and both targets are emitted in order.
- **Async reset:** assert `rst_ni` low with entries queued and a valid output → all outputs take reset values immediately, without waiting for a clock edge.
